// File: rtl/fractal_sync_mc_fifo_pkg.sv
// Shared sizing helpers for the multi-channel synchronisation FIFO.
// fifo_t is supplied by the instantiator, so no element typedefs live here.
package fractal_sync_mc_fifo_pkg;

   localparam int unsigned MIN_PTR_W = 1;

   // A depth-1 channel still needs a 1-bit pointer to keep vector widths legal.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : MIN_PTR_W;
   endfunction

endpackage

// File: rtl/fractal_sync_mc_fifo_ch.sv
// One FIFO channel: storage, wrapping pointers, level counter and sticky flags.
// Full/empty come from the level counter, so any depth works, not only powers of two.
module fractal_sync_mc_fifo_ch
   import fractal_sync_mc_fifo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter type         fifo_t     = logic,
   parameter bit          COMB_OUT   = 1'b1,
   parameter int unsigned AF_THRESH  = 1,
   parameter int unsigned LEVEL_W    = $clog2(FIFO_DEPTH+1)
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               push_i,
   input  fifo_t              element_i,
   input  logic               pop_i,
   output fifo_t              element_o,
   output logic               empty_o,
   output logic               full_o,
   output logic               almost_full_o,
   output logic [LEVEL_W-1:0] level_o,
   output logic               ovf_o,
   output logic               udf_o
);

   localparam int unsigned        PTR_W     = ptr_width(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(FIFO_DEPTH-1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(FIFO_DEPTH);
   localparam logic [LEVEL_W-1:0] LEVEL_AF  = LEVEL_W'(FIFO_DEPTH-AF_THRESH);

   fifo_t              mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LEVEL_W-1:0] level_q;
   logic               ovf_q, udf_q;

   logic empty_reg, pass_thru, pop_acc, push_acc, bypass, write_en, read_en;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty_reg     = (level_q == '0);
   assign full_o        = (level_q == LEVEL_MAX);
   assign almost_full_o = (level_q >= LEVEL_AF);
   assign pass_thru     = COMB_OUT & empty_reg & push_i;
   assign pop_acc       = pop_i & (~empty_reg | pass_thru);
   assign push_acc      = push_i & (~full_o | pop_acc);
   // Same-cycle push and pop on an empty fall-through channel never touches storage.
   assign bypass        = pass_thru & pop_acc;
   assign write_en      = push_acc & ~bypass;
   assign read_en       = pop_acc & ~bypass;

   assign element_o = pass_thru ? element_i : mem_q[rd_ptr_q];
   assign empty_o   = empty_reg & ~(COMB_OUT & push_i);
   assign level_o   = level_q;
   assign ovf_o     = ovf_q;
   assign udf_o     = udf_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (write_en) begin
            mem_q[wr_ptr_q] <= element_i;
            wr_ptr_q        <= ptr_next(wr_ptr_q);
         end
         if (read_en) rd_ptr_q <= ptr_next(rd_ptr_q);
         if (write_en && !read_en)      level_q <= level_q + 1'b1;
         else if (read_en && !write_en) level_q <= level_q - 1'b1;
         if (push_i && !push_acc) ovf_q <= 1'b1;
         if (pop_i && !pop_acc)   udf_q <= 1'b1;
      end
   end

endmodule

// File: rtl/fractal_sync_mc_fifo.sv
// Multi-channel synchronisation FIFO: NUM_CH independent queues, one push and
// one pop per channel per cycle, sitting between fractal_sync tree levels.
module fractal_sync_mc_fifo
   import fractal_sync_mc_fifo_pkg::*;
#(
   parameter int unsigned NUM_CH     = 1,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter type         fifo_t     = logic,
   parameter bit          COMB_OUT   = 1'b1,
   parameter int unsigned AF_THRESH  = 1,
   parameter int unsigned LEVEL_W    = $clog2(FIFO_DEPTH+1)
)(
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic  [NUM_CH-1:0]             flush_i,
   input  logic  [NUM_CH-1:0]             push_i,
   input  fifo_t [NUM_CH-1:0]             element_i,
   input  logic  [NUM_CH-1:0]             pop_i,
   output fifo_t [NUM_CH-1:0]             element_o,
   output logic  [NUM_CH-1:0]             empty_o,
   output logic  [NUM_CH-1:0]             full_o,
   output logic  [NUM_CH-1:0]             almost_full_o,
   output logic  [NUM_CH-1:0][LEVEL_W-1:0] level_o,
   output logic  [NUM_CH-1:0]             ovf_o,
   output logic  [NUM_CH-1:0]             udf_o
);

   if (NUM_CH == 0) begin : g_chk_num_ch
      $error("fractal_sync_mc_fifo: NUM_CH must be > 0");
   end
   if (FIFO_DEPTH == 0) begin : g_chk_depth
      $error("fractal_sync_mc_fifo: FIFO_DEPTH must be > 0");
   end
   if (AF_THRESH >= FIFO_DEPTH) begin : g_chk_af
      $error("fractal_sync_mc_fifo: AF_THRESH must be < FIFO_DEPTH");
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fractal_sync_mc_fifo_ch #(
         .FIFO_DEPTH (FIFO_DEPTH),
         .fifo_t     (fifo_t),
         .COMB_OUT   (COMB_OUT),
         .AF_THRESH  (AF_THRESH),
         .LEVEL_W    (LEVEL_W)
      ) u_ch (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .flush_i       (flush_i[c]),
         .push_i        (push_i[c]),
         .element_i     (element_i[c]),
         .pop_i         (pop_i[c]),
         .element_o     (element_o[c]),
         .empty_o       (empty_o[c]),
         .full_o        (full_o[c]),
         .almost_full_o (almost_full_o[c]),
         .level_o       (level_o[c]),
         .ovf_o         (ovf_o[c]),
         .udf_o         (udf_o[c])
      );
   end

endmodule

// File: tb/tb_fractal_sync_mc_fifo.sv
// Bench for fractal_sync_mc_fifo: two instances (DEPTH=3 registered, DEPTH=2
// fall-through), each with two channels, checked against a queue-based model.
module tb_fractal_sync_mc_fifo;

   typedef logic [7:0] data_t;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic  [1:0]      flush_a, push_a, pop_a, empty_a, full_a, af_a, ovf_a, udf_a;
   data_t [1:0]      elem_in_a, elem_out_a;
   logic  [1:0][1:0] level_a;
   logic  [1:0]      flush_b, push_b, pop_b, empty_b, full_b, af_b, ovf_b, udf_b;
   data_t [1:0]      elem_in_b, elem_out_b;
   logic  [1:0][1:0] level_b;

   fractal_sync_mc_fifo #(
      .NUM_CH(2), .FIFO_DEPTH(3), .fifo_t(data_t), .COMB_OUT(1'b0), .AF_THRESH(1)
   ) dut_a (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_a), .push_i(push_a),
      .element_i(elem_in_a), .pop_i(pop_a), .element_o(elem_out_a),
      .empty_o(empty_a), .full_o(full_a), .almost_full_o(af_a),
      .level_o(level_a), .ovf_o(ovf_a), .udf_o(udf_a)
   );

   fractal_sync_mc_fifo #(
      .NUM_CH(2), .FIFO_DEPTH(2), .fifo_t(data_t), .COMB_OUT(1'b1), .AF_THRESH(1)
   ) dut_b (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_b), .push_i(push_b),
      .element_i(elem_in_b), .pop_i(pop_b), .element_o(elem_out_b),
      .empty_o(empty_b), .full_o(full_b), .almost_full_o(af_b),
      .level_o(level_b), .ovf_o(ovf_b), .udf_o(udf_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference: channels 0,1 belong to dut_a, channels 2,3 to dut_b.
   data_t mq [4][$];
   bit    m_ovf [4];
   bit    m_udf [4];

   function automatic int m_depth(input int k);
      return (k < 2) ? 3 : 2;
   endfunction

   function automatic bit m_comb(input int k);
      return (k >= 2);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int k, input bit fl, input bit pu, input bit po, input data_t d);
      logic ci;
      ci = k[0];
      if (k < 2) begin
         flush_a[ci] = fl; push_a[ci] = pu; pop_a[ci] = po; elem_in_a[ci] = d;
      end else begin
         flush_b[ci] = fl; push_b[ci] = pu; pop_b[ci] = po; elem_in_b[ci] = d;
      end
   endtask

   task automatic clear_in();
      for (int k = 0; k < 4; k++) set_in(k, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic get_in(input int k, output bit fl, output bit pu, output bit po, output data_t d);
      logic ci;
      ci = k[0];
      if (k < 2) begin
         fl = flush_a[ci]; pu = push_a[ci]; po = pop_a[ci]; d = elem_in_a[ci];
      end else begin
         fl = flush_b[ci]; pu = push_b[ci]; po = pop_b[ci]; d = elem_in_b[ci];
      end
   endtask

   task automatic get_out(input int k, output data_t el, output logic em, output logic fu,
                          output logic af, output logic [1:0] lv, output logic ov, output logic ud);
      logic ci;
      ci = k[0];
      if (k < 2) begin
         el = elem_out_a[ci]; em = empty_a[ci]; fu = full_a[ci]; af = af_a[ci];
         lv = level_a[ci]; ov = ovf_a[ci]; ud = udf_a[ci];
      end else begin
         el = elem_out_b[ci]; em = empty_b[ci]; fu = full_b[ci]; af = af_b[ci];
         lv = level_b[ci]; ov = ovf_b[ci]; ud = udf_b[ci];
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         mq[k].delete();
         m_ovf[k] = 1'b0;
         m_udf[k] = 1'b0;
      end
   endtask

   task automatic check_all();
      bit fl, pu, po;
      data_t d, el;
      logic em, fu, af, ov, ud;
      logic [1:0] lv;
      int sz;
      for (int k = 0; k < 4; k++) begin
         get_in(k, fl, pu, po, d);
         get_out(k, el, em, fu, af, lv, ov, ud);
         sz = mq[k].size();
         check_val($sformatf("level[%0d]", k), 32'(lv), 32'(sz));
         check_val($sformatf("empty[%0d]", k), 32'(em), 32'((sz == 0) && !(m_comb(k) && pu)));
         check_val($sformatf("full[%0d]", k), 32'(fu), 32'(sz == m_depth(k)));
         check_val($sformatf("afull[%0d]", k), 32'(af), 32'(sz >= m_depth(k) - 1));
         check_val($sformatf("ovf[%0d]", k), 32'(ov), 32'(m_ovf[k]));
         check_val($sformatf("udf[%0d]", k), 32'(ud), 32'(m_udf[k]));
         if (sz > 0) check_val($sformatf("head[%0d]", k), 32'(el), 32'(mq[k][0]));
         else if (m_comb(k) && pu) check_val($sformatf("fallthru[%0d]", k), 32'(el), 32'(d));
      end
   endtask

   task automatic model_update();
      bit fl, pu, po, pop_ok, push_ok;
      data_t d;
      int sz;
      for (int k = 0; k < 4; k++) begin
         get_in(k, fl, pu, po, d);
         sz = mq[k].size();
         if (rst_i || fl) begin
            mq[k].delete();
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
         end else begin
            pop_ok  = po && (sz > 0 || (m_comb(k) && pu));
            push_ok = pu && (sz < m_depth(k) || pop_ok);
            if (!(sz == 0 && pop_ok && push_ok)) begin
               if (pop_ok)  void'(mq[k].pop_front());
               if (push_ok) mq[k].push_back(d);
            end
            if (pu && !push_ok) m_ovf[k] = 1'b1;
            if (po && !pop_ok)  m_udf[k] = 1'b1;
         end
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      #1;
      check_all();
      @(posedge clk_i);
      model_update();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1;
      clear_in();
      model_reset();
      repeat (2) @(negedge clk_i);
      #1;
      check_val("rst_elem_a", 32'(elem_out_a[0]), 32'h0);
      check_val("rst_elem_b", 32'(elem_out_b[1]), 32'h0);
      check_val("rst_empty_a", 32'(empty_a), 32'h3);
      check_val("rst_empty_b", 32'(empty_b), 32'h3);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Fill and drain, DEPTH=3 registered output
      set_in(0, 0, 1, 0, 8'h0A); tick();
      set_in(0, 0, 1, 0, 8'h0B); tick();
      set_in(0, 0, 1, 0, 8'h0C); tick();
      clear_in(); #1;
      check_val("fill_level", 32'(level_a[0]), 32'd3);
      check_val("fill_full", 32'(full_a[0]), 32'd1);
      check_val("fill_afull", 32'(af_a[0]), 32'd1);
      check_val("drain_0", 32'(elem_out_a[0]), 32'h0A);
      set_in(0, 0, 0, 1, 8'h00); tick();
      check_val("drain_1", 32'(elem_out_a[0]), 32'h0B);
      tick();
      check_val("drain_2", 32'(elem_out_a[0]), 32'h0C);
      tick();
      clear_in(); #1;
      check_val("drain_empty", 32'(empty_a[0]), 32'd1);

      // Non-power-of-2 wrap at level 1
      set_in(0, 0, 1, 0, 8'h10); tick();
      for (int i = 0; i < 7; i++) begin
         set_in(0, 0, 1, 1, data_t'(8'h11 + i)); tick();
      end
      clear_in(); #1;
      check_val("wrap_level", 32'(level_a[0]), 32'd1);
      check_val("wrap_head", 32'(elem_out_a[0]), 32'h17);
      set_in(0, 0, 0, 1, 8'h00); tick();
      clear_in();

      // Fall-through on empty channel, COMB_OUT=1
      set_in(2, 0, 1, 1, 8'h05); #1;
      check_val("ft_elem", 32'(elem_out_b[0]), 32'h05);
      check_val("ft_empty", 32'(empty_b[0]), 32'd0);
      tick();
      clear_in(); #1;
      check_val("ft_level", 32'(level_b[0]), 32'd0);

      // DEPTH=2 boundaries: overflow, full push+pop, underflow
      set_in(3, 0, 1, 0, 8'h21); tick();
      set_in(3, 0, 1, 0, 8'h22); tick();
      set_in(3, 0, 1, 0, 8'h23); tick();
      clear_in(); #1;
      check_val("ovf_set", 32'(ovf_b[1]), 32'd1);
      check_val("ovf_keep", 32'(elem_out_b[1]), 32'h21);
      set_in(3, 0, 1, 1, 8'h24); tick();
      clear_in(); #1;
      check_val("fullpp_level", 32'(level_b[1]), 32'd2);
      check_val("fullpp_head", 32'(elem_out_b[1]), 32'h22);
      set_in(1, 0, 0, 1, 8'h00); tick();
      clear_in(); #1;
      check_val("udf_set", 32'(udf_a[1]), 32'd1);

      // Flush with isolation on dut_a
      set_in(1, 1, 0, 0, 8'h00); tick();
      set_in(0, 0, 1, 0, 8'h31); set_in(1, 0, 1, 0, 8'h41); tick();
      set_in(0, 0, 1, 0, 8'h32); set_in(1, 0, 1, 0, 8'h42); tick();
      clear_in();
      set_in(0, 0, 1, 0, 8'h33); tick();
      set_in(0, 0, 1, 0, 8'h34); tick();
      set_in(0, 1, 1, 0, 8'h35); tick();
      clear_in(); #1;
      check_val("flush_level", 32'(level_a[0]), 32'd0);
      check_val("flush_ovf", 32'(ovf_a[0]), 32'd0);
      check_val("iso_level", 32'(level_a[1]), 32'd2);
      check_val("iso_head", 32'(elem_out_a[1]), 32'h41);

      // Reset mid-stream
      set_in(0, 0, 1, 0, 8'h51); tick();
      set_in(0, 0, 1, 0, 8'h52); tick();
      clear_in();
      rst_i = 1'b1;
      model_reset();
      #1;
      check_val("midrst_empty", 32'(empty_a[0]), 32'd1);
      check_val("midrst_level", 32'(level_a[0]), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      set_in(0, 0, 1, 0, 8'h77); tick();
      clear_in(); #1;
      check_val("postrst_head", 32'(elem_out_a[0]), 32'h77);

      // Randomised traffic on all four channels
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 4; k++)
            set_in(k, ($urandom_range(99) < 3), ($urandom_range(99) < 60),
                   ($urandom_range(99) < 50), data_t'($urandom));
         tick();
      end
      clear_in();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
